// File: rtl/uart_pkg.sv
// Shared types for the UART receiver with receive FIFO.
// Holds the FSM enum, the parity mode and the entry layout.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'd0,
    PAR_ODD      = 2'd1,
    PAR_EVEN     = 2'd2,
    PAR_NONE_ALT = 2'd3
  } parity_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK_WAIT
  } rx_state_e;

  typedef struct packed {
    logic                     break_det;
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with drop-on-full and a zeroed empty head.
// Push while full is accepted only if a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_rd_ready,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_drop
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] L_FULL = AW1'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == L_FULL);
  assign w_pop   = i_rd_ready && !w_empty;
  assign w_wr    = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_count = r_count;
  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];

  // Storage write; contents are masked by the count when empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver feeding a small receive FIFO.
// Majority-voted bits, parity/frame/break flags per entry.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tick_ovs,
  input  logic                        rx_pin,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic                        rx_ready,
  input  logic                        clear_overrun,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        rx_valid,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        break_det,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW = $clog2(OVS_FACTOR);
  localparam int EW = $bits(rx_entry_t);
  localparam logic [CW-1:0] L_MIDM = CW'(OVS_FACTOR / 2 - 1);
  localparam logic [CW-1:0] L_MID  = CW'(OVS_FACTOR / 2);
  localparam logic [CW-1:0] L_MIDP = CW'(OVS_FACTOR / 2 + 1);
  localparam logic [CW-1:0] L_LAST = CW'(OVS_FACTOR - 1);
  localparam logic [3:0]    L_LBIT = 4'(DATA_BITS - 1);

  if (OVS_FACTOR < 8 ||
      (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
    $fatal(1, "OVS_FACTOR must be a power of 2 >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $fatal(1, "DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of 2 >= 2");
  end

  logic [1:0]           r_sync;
  rx_state_e            r_state;
  logic [CW-1:0]        r_ovs;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0;
  logic                 r_s1;
  parity_mode_e         r_pmode;
  logic                 r_two;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_brk;
  logic                 r_ovr;
  logic                 w_rx;
  logic                 w_vote;
  logic                 w_par_en;
  logic                 w_vpt;
  logic                 w_last;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_unused;
  rx_entry_t            w_entry;
  rx_entry_t            w_head;

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], rx_pin};
  end

  assign w_rx     = r_sync[1];
  assign w_vote   = maj3(r_s0, r_s1, w_rx);
  assign w_par_en = (r_pmode == PAR_ODD) ||
                    (r_pmode == PAR_EVEN);
  assign w_vpt    = (r_ovs == L_MIDP);
  assign w_last   = (r_ovs == L_LAST);
  assign w_push   = tick_ovs && w_vpt &&
                    ((r_state == S_STOP1 && !r_two) ||
                     r_state == S_STOP2);

  // Entry assembled with the final stop vote folded in.
  always_comb begin
    w_entry                      = '0;
    w_entry.break_det            = r_brk & ~w_vote;
    w_entry.frame_err            = r_ferr | ~w_vote;
    w_entry.parity_err           = r_perr;
    w_entry.data[DATA_BITS-1:0]  = r_shift;
  end

  // Frame FSM, advancing only on oversample ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ovs    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_s0     <= 1'b0;
      r_s1     <= 1'b0;
      r_pmode  <= PAR_NONE;
      r_two    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_brk    <= 1'b0;
    end else if (tick_ovs) begin
      r_ovs <= r_ovs + 1'b1;
      if (r_ovs == L_MIDM) r_s0 <= w_rx;
      if (r_ovs == L_MID)  r_s1 <= w_rx;
      case (r_state)
        S_IDLE: begin
          r_ovs <= '0;
          if (!w_rx) begin
            r_state  <= S_START;
            r_pmode  <= parity_mode_e'(parity_mode);
            r_two    <= two_stop;
            r_bitcnt <= '0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_brk    <= 1'b1;
          end
        end
        S_START: begin
          if (w_vpt && w_vote) r_state <= S_IDLE;
          else if (w_last)     r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_vpt) begin
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_vote) r_brk <= 1'b0;
          end
          if (w_last) begin
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == L_LBIT) begin
              r_bitcnt <= '0;
              r_state  <= w_par_en ? S_PARITY : S_STOP1;
            end
          end
        end
        S_PARITY: begin
          if (w_vpt) begin
            if (r_pmode == PAR_EVEN) r_perr <= ^r_shift ^ w_vote;
            else                     r_perr <= ~(^r_shift ^ w_vote);
            if (w_vote) r_brk <= 1'b0;
          end
          if (w_last) r_state <= S_STOP1;
        end
        S_STOP1: begin
          if (w_vpt) begin
            if (!w_vote) r_ferr <= 1'b1;
            else         r_brk  <= 1'b0;
            if (!r_two)
              r_state <= w_entry.break_det ? S_BREAK_WAIT : S_IDLE;
          end else if (w_last) begin
            r_state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (w_vpt)
            r_state <= w_entry.break_det ? S_BREAK_WAIT : S_IDLE;
        end
        S_BREAK_WAIT: begin
          r_ovs <= '0;
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_wdata    (w_entry),
    .i_rd_ready (rx_ready),
    .o_rdata    (w_head),
    .o_count    (fifo_count),
    .o_drop     (w_drop)
  );

  // Sticky overrun; a drop in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           r_ovr <= 1'b0;
    else if (w_drop)        r_ovr <= 1'b1;
    else if (clear_overrun) r_ovr <= 1'b0;
  end

  assign rx_valid   = (fifo_count != '0);
  assign rx_data    = w_head.data[DATA_BITS-1:0];
  assign parity_err = w_head.parity_err;
  assign frame_err  = w_head.frame_err;
  assign break_det  = w_head.break_det;
  assign overrun    = r_ovr;
  assign w_unused   = ^w_head.data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (8 bits, x16, depth 4).
// Ticks every second clock; bits last 16 ticks.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_ovs = 1'b0;
  logic       rx_pin = 1'b1;
  logic [1:0] parity_mode = 2'd0;
  logic       two_stop = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       break_det;
  logic       overrun;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [14:0] exp_h;
  logic [14:0] got_h;

  uart_rx_fifo #(
    .DATA_BITS  (8),
    .OVS_FACTOR (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick_ovs      (tick_ovs),
    .rx_pin        (rx_pin),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .rx_ready      (rx_ready),
    .clear_overrun (clear_overrun),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .break_det     (break_det),
    .overrun       (overrun),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) tick_ovs = ~tick_ovs;

  assign got_h = {rx_valid, fifo_count, rx_data,
                  parity_err, frame_err, break_det};

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick_ovs) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_pin = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic [1:0] pm,
                            input logic       ts,
                            input logic       pb,
                            input logic       st2);
    @(negedge clk);
    parity_mode = pm;
    two_stop    = ts;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pm == 2'd1 || pm == 2'd2) send_bit(pb);
    send_bit(1'b1);
    if (ts) send_bit(st2);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({got_h, overrun} !== 16'h0) begin
      n_errors++;
      $display("FAIL reset_state: got %h/%b want 0000/0",
               got_h, overrun);
    end
    reset_n = 1'b1;
    wait_ticks(8);
  endtask

  task automatic test_basic();
    send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'h55, 3'b000};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL basic_55: got %h want %h", got_h, exp_h);
    end
    pop_one();
    n_checks++;
    if (got_h !== 15'h0) begin
      n_errors++;
      $display("FAIL basic_empty: got %h want 0000", got_h);
    end
  endtask

  task automatic test_parity();
    send_frame(8'hA3, 2'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'hA3, 3'b100};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL even_p1: got %h want %h", got_h, exp_h);
    end
    pop_one();
    send_frame(8'hA3, 2'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'hA3, 3'b000};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL even_p0: got %h want %h", got_h, exp_h);
    end
    pop_one();
    send_frame(8'hA3, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'hA3, 3'b100};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL odd_p0: got %h want %h", got_h, exp_h);
    end
    pop_one();
  endtask

  task automatic test_two_stop();
    send_frame(8'h5A, 2'd0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'h5A, 3'b010};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL stop2_low: got %h want %h", got_h, exp_h);
    end
    pop_one();
    send_frame(8'h96, 2'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'h96, 3'b000};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL stop2_ok: got %h want %h", got_h, exp_h);
    end
    pop_one();
    @(negedge clk);
    two_stop = 1'b0;
  endtask

  task automatic test_false_start();
    @(negedge clk);
    rx_pin = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx_pin = 1'b1;
    wait_ticks(40);
    @(negedge clk);
    n_checks++;
    if (got_h !== 15'h0) begin
      n_errors++;
      $display("FAIL false_start: got %h want 0000", got_h);
    end
    send_frame(8'h3C, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'h3C, 3'b000};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL after_false: got %h want %h", got_h, exp_h);
    end
    pop_one();
  endtask

  task automatic test_overrun();
    for (int k = 1; k <= 5; k++)
      send_frame(8'(k), 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd4, 8'h01, 3'b000};
    n_checks++;
    if ({got_h, overrun} !== {exp_h, 1'b1}) begin
      n_errors++;
      $display("FAIL ovr_full: got %h/%b want %h/1",
               got_h, overrun, exp_h);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rx_data !== 8'(k) || rx_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL ovr_pop%0d: got %h/%b want %h/1",
                 k, rx_data, rx_valid, 8'(k));
      end
      pop_one();
    end
    n_checks++;
    if ({got_h, overrun} !== {15'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL ovr_drained: got %h/%b want 0000/1",
               got_h, overrun);
    end
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
  endtask

  task automatic test_break();
    @(negedge clk);
    rx_pin = 1'b0;
    wait_ticks(320);
    @(negedge clk);
    rx_pin = 1'b1;
    wait_ticks(32);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'h00, 3'b011};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL break_entry: got %h want %h", got_h, exp_h);
    end
    send_frame(8'h7E, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd2, 8'h00, 3'b011};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL break_then: got %h want %h", got_h, exp_h);
    end
    pop_one();
    exp_h = {1'b1, 3'd1, 8'h7E, 3'b000};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL break_7e: got %h want %h", got_h, exp_h);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd1) begin
      n_errors++;
      $display("FAIL pre_reset_cnt: got %0d want 1", fifo_count);
    end
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    rx_pin = 1'b1;
    wait_ticks(6);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({got_h, overrun} !== 16'h0) begin
      n_errors++;
      $display("FAIL in_reset: got %h/%b want 0000/0",
               got_h, overrun);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(160);
    @(negedge clk);
    n_checks++;
    if (got_h !== 15'h0) begin
      n_errors++;
      $display("FAIL post_reset_idle: got %h want 0000", got_h);
    end
    send_frame(8'hC4, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    exp_h = {1'b1, 3'd1, 8'hC4, 3'b000};
    n_checks++;
    if (got_h !== exp_h) begin
      n_errors++;
      $display("FAIL reset_c4: got %h want %h", got_h, exp_h);
    end
    pop_one();
    n_checks++;
    if (got_h !== 15'h0) begin
      n_errors++;
      $display("FAIL reset_end: got %h want 0000", got_h);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_false_start();
    test_overrun();
    test_break();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVS_FACTOR, default 16, oversample ticks per bit; power of 2, >= 8; otherwise elaboration SHALL fail with $fatal.
REQ-003 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of 2, >= 2.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 tick_ovs  in  1  one-clk strobe at OVS_FACTOR x baud; the frame FSM advances only on cycles with tick_ovs=1.
REQ-007 rx_pin  in  1  asynchronous serial line, idle high.
REQ-008 parity_mode  in  2  0=none, 1=odd, 2=even, 3=treated as none.
REQ-009 two_stop  in  1  1 = two stop bits checked.
REQ-010 rx_ready  in  1  consumer accepts the head entry.
REQ-011 clear_overrun  in  1  clears the sticky overrun flag.
REQ-012 rx_data  out  DATA_BITS  head entry data, LSB = first received bit.
REQ-013 rx_valid  out  1  FIFO non-empty.
REQ-014 parity_err, frame_err, break_det  out  1 each  flags of the head entry.
REQ-015 overrun  out  1  sticky; a frame was dropped because the FIFO was full.
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Function
REQ-017 rx_pin SHALL pass through a 2-flop synchroniser; all sampling SHALL use the synchronised value.
REQ-018 Sampling SHALL be a majority vote of 3 samples taken at ticks MID-1, MID and MID+1 of each bit, where MID = OVS_FACTOR/2 and tick counting starts at 0.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
REQ-020 IDLE -> START on a tick with the synchronised line low; the oversample counter is cleared.
REQ-021 START: if the vote at MID is 1, the FSM SHALL treat the start as false and return to IDLE with no push; otherwise it SHALL enter DATA at the last tick.
REQ-022 DATA: receive DATA_BITS bits LSB-first, one per OVS_FACTOR ticks; after the last bit, go to PARITY if parity_mode is 1 or 2, else to STOP1.
REQ-023 Parity error: even mode -> XOR of data and parity bit is 1; odd mode -> XOR of data and parity bit is 0.
REQ-024 STOP1: a vote of 0 sets frame_err; go to STOP2 if two_stop=1, else complete; a STOP2 vote of 0 also sets frame_err.
REQ-025 Completion at the MID+1 tick of the final stop bit: push {break_det, frame_err, parity_err, data}, then IDLE, or BREAK_WAIT if break_det is set.
REQ-026 break_det = all data bits 0, parity bit 0 (if enabled) and all stop votes 0.
REQ-027 BREAK_WAIT -> IDLE only once the synchronised line reads high on a tick; no frames are detected meanwhile.
REQ-028 parity_mode and two_stop SHALL be sampled on the IDLE->START transition and held for the frame.
REQ-029 FIFO interface: rx_valid = (fifo_count != 0); rx_data and the flags show the head entry; a pop occurs on any cycle with rx_valid && rx_ready.
REQ-030 A pushed entry SHALL appear on the outputs in the clk cycle after the push.
REQ-031 Push while full with no pop in the same cycle: the entry is dropped and overrun is set; FIFO contents are unchanged.
REQ-032 Push and pop in the same cycle: both occur and fifo_count is unchanged, including when full; when empty, only the push occurs.
REQ-033 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 overrun is cleared by clear_overrun=1; if a set and clear_overrun occur in the same cycle, set wins.
REQ-035 While outputs are empty, rx_data and the flags SHALL be 0.

Reset
REQ-036 reset_n=0 SHALL immediately force: FSM=IDLE, counters 0, synchroniser flops 1, FIFO empty, rx_valid=0, rx_data=0, all flags 0, overrun=0, fifo_count=0.
REQ-037 Reset mid-frame SHALL abort the frame with no push; reception SHALL resume at the next start edge after release.

Structure
REQ-038 Package uart_pkg SHALL hold parity_mode_e, the rx FSM enum, and the rx entry struct {break_det, frame_err, parity_err, data}.
REQ-039 The FIFO SHALL be a separate sub-module sync_fifo, parametrised by width and depth.

Verification
All scenarios use DATA_BITS=8, OVS_FACTOR=16, FIFO_DEPTH=4.
REQ-040 Frame 0x55, no parity, 1 stop -> one entry: rx_data=0x55, all flags 0, fifo_count=1.
REQ-041 Frame 0xA3 (4 ones), even parity, parity bit driven 1 -> rx_data=0xA3, parity_err=1; the same frame with parity bit 0 -> parity_err=0.
REQ-042 Line low for 4 ticks, then high -> no entry; rx_valid stays 0; the FSM is back in IDLE.
REQ-043 Frames 0x01..0x05 with rx_ready=0 -> fifo_count=4, overrun=1; popping yields 0x01..0x04 and 0x05 is lost; clear_overrun -> overrun=0.
REQ-044 Line low for 20 bit times, then high, then frame 0x7E -> one entry {0x00, frame_err=1, break_det=1}, then one entry 0x7E with flags 0.
REQ-045 reset_n pulsed low during data bit 3, then frame 0xC4 -> outputs at reset values during reset; exactly one entry 0xC4 afterwards.
